// File: rtl/mem_arb_pkg.sv
// Shared types and decoder access-mode encodings for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_DM = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

  localparam logic [2:0] MEM_B    = 3'b000;
  localparam logic [2:0] MEM_H    = 3'b001;
  localparam logic [2:0] MEM_W    = 3'b010;
  localparam logic [2:0] MEM_BU   = 3'b011;
  localparam logic [2:0] MEM_HU   = 3'b100;
  localparam logic [2:0] MEM_NONE = 3'b111;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatting: store enables/replication, load extension,
// and legality/alignment check of a data-side request.
module mem_lane_fmt
  import mem_arb_pkg::*;
(
  input  logic                             rd,
  input  logic                             wr,
  input  logic [2:0]                       mode,
  input  logic [1:0]                       off,
  input  logic [NUM_LANES*LANE_W-1:0]      wdata,
  output logic [NUM_LANES-1:0]             be,
  output logic [NUM_LANES*LANE_W-1:0]      wdata_rep,
  output logic                             err,
  input  logic [2:0]                       ld_mode,
  input  logic [1:0]                       ld_off,
  input  logic [NUM_LANES*LANE_W-1:0]      rdata_raw,
  output logic [NUM_LANES*LANE_W-1:0]      rdata_ext
);

  logic [LANE_W-1:0]   ld_byte;
  logic [2*LANE_W-1:0] ld_half;

  always_comb begin
    be        = 4'hF;
    wdata_rep = '0;
    if (wr) begin
      case (mode)
        MEM_B:   begin be = 4'b0001 << off; wdata_rep = {4{wdata[7:0]}};  end
        MEM_H:   begin be = 4'b0011 << off; wdata_rep = {2{wdata[15:0]}}; end
        default: begin be = 4'hF;           wdata_rep = wdata;            end
      endcase
    end
  end

  // Unassigned encodings (101, 110) are rejected along with MEM_NONE.
  always_comb begin
    err = rd & wr;
    case (mode)
      MEM_B, MEM_BU: ;
      MEM_H, MEM_HU: if (off[0]) err = 1'b1;
      MEM_W:         if (off != 2'b00) err = 1'b1;
      default:       err = 1'b1;
    endcase
    if (wr && (mode == MEM_BU || mode == MEM_HU)) err = 1'b1;
  end

  always_comb begin
    ld_byte   = rdata_raw[{ld_off, 3'b000} +: LANE_W];
    ld_half   = ld_off[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    rdata_ext = rdata_raw;
    case (ld_mode)
      MEM_B:   rdata_ext = {{24{ld_byte[7]}}, ld_byte};
      MEM_H:   rdata_ext = {{16{ld_half[15]}}, ld_half};
      MEM_BU:  rdata_ext = {24'h0, ld_byte};
      MEM_HU:  rdata_ext = {16'h0, ld_half};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: arbitration,
// req/ack sequencing with timeout, and registered one-cycle completion pulses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_rd_en,
  input  logic        dm_wr_en,
  input  logic [2:0]  dm_acc_mode,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

  arb_state_t        state;
  logic [TO_W-1:0]   to_cnt;
  logic [FAIR_W-1:0] fair_cnt;
  logic [2:0]        ld_mode;
  logic [1:0]        ld_off;

  logic        dm_req, pick_if, dm_chk_err;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign dm_req  = dm_rd_en | dm_wr_en;
  assign pick_if = if_req & (~dm_req | (fair_cnt == FAIR_W'(FAIR_LIMIT)));

  mem_lane_fmt u_fmt (
    .rd        (dm_rd_en),
    .wr        (dm_wr_en),
    .mode      (dm_acc_mode),
    .off       (dm_addr[1:0]),
    .wdata     (dm_wdata),
    .be        (st_be),
    .wdata_rep (st_wdata),
    .err       (dm_chk_err),
    .ld_mode   (ld_mode),
    .ld_off    (ld_off),
    .rdata_raw (mem_rdata),
    .rdata_ext (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      to_cnt    <= '0;
      fair_cnt  <= '0;
      ld_mode   <= '0;
      ld_off    <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (!if_req) fair_cnt <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_if) begin
            fair_cnt <= '0;
            if (if_addr[1:0] != 2'b00) begin
              state   <= ARB_RESP;
              if_done <= 1'b1;
              if_err  <= 1'b1;
            end else begin
              state     <= ARB_WAIT_IF;
              to_cnt    <= '0;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {if_addr[31:2], 2'b00};
              mem_be    <= 4'hF;
              mem_wdata <= '0;
            end
          end else if (dm_req) begin
            if (if_req) fair_cnt <= fair_cnt + 1'b1;
            ld_mode <= dm_acc_mode;
            ld_off  <= dm_addr[1:0];
            if (dm_chk_err) begin
              state   <= ARB_RESP;
              dm_done <= 1'b1;
              dm_err  <= 1'b1;
            end else begin
              state     <= ARB_WAIT_DM;
              to_cnt    <= '0;
              mem_req   <= 1'b1;
              mem_we    <= dm_wr_en;
              mem_addr  <= {dm_addr[31:2], 2'b00};
              mem_be    <= st_be;
              mem_wdata <= st_wdata;
            end
          end
        end
        ARB_WAIT_IF, ARB_WAIT_DM: begin
          // Either an ack or the last allowed cycle closes the access.
          if (mem_ack || to_cnt == TO_W'(TIMEOUT - 1)) begin
            state     <= ARB_RESP;
            to_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (state == ARB_WAIT_IF) begin
              if_done  <= 1'b1;
              if_err   <= ~mem_ack;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dm_done  <= 1'b1;
              dm_err   <= ~mem_ack;
              dm_rdata <= (mem_ack && !mem_we) ? ld_data : '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          if_err   <= 1'b0;
          if_rdata <= '0;
          dm_err   <= 1'b0;
          dm_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: handshake latency, lane formatting,
// pre-check errors, fairness, timeout and mid-access reset.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_rd_en, dm_wr_en;
  logic [2:0]  dm_acc_mode;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.TIMEOUT(16), .FAIR_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_acc_mode(dm_acc_mode), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dm_issue(input logic rd, input logic wr, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] wd);
    dm_rd_en = rd; dm_wr_en = wr; dm_acc_mode = mode; dm_addr = addr; dm_wdata = wd;
    step();
    dm_rd_en = 1'b0; dm_wr_en = 1'b0;
  endtask

  task automatic ack_step(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    int ev, cyc, cnt;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_rd_en = 1'b0; dm_wr_en = 1'b0; dm_acc_mode = MEM_W; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dones", {30'b0, if_done, dm_done}, 32'd0);

    // fetch: grant cycle 0, mem_req cycle 1, ack cycle 2, done cycle 3
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("if_mem_req", {31'b0, mem_req}, 32'd1);
    chk("if_mem_addr", mem_addr, 32'h100);
    chk("if_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    chk("if_no_done_early", {31'b0, if_done}, 32'd0);
    ack_step(32'h00500093);
    chk("if_done", {31'b0, if_done}, 32'd1);
    chk("if_rdata", if_rdata, 32'h00500093);
    chk("if_err", {31'b0, if_err}, 32'd0);
    if_req = 1'b0;
    step();
    chk("if_done_pulse", {31'b0, if_done}, 32'd0);

    // LB / LBU from the top byte lane
    dm_issue(1'b1, 1'b0, MEM_B, 32'h203, '0);
    chk("lb_addr", mem_addr, 32'h200);
    ack_step(32'h80123456);
    chk("lb_done", {31'b0, dm_done}, 32'd1);
    chk("lb_rdata", dm_rdata, 32'hFFFFFF80);
    step();
    dm_issue(1'b1, 1'b0, MEM_BU, 32'h203, '0);
    ack_step(32'h80123456);
    chk("lbu_rdata", dm_rdata, 32'h00000080);
    step();

    // stores: lane enables and replication
    dm_issue(1'b0, 1'b1, MEM_H, 32'h202, 32'h1234ABCD);
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_we", {31'b0, mem_we}, 32'd1);
    ack_step('0);
    chk("sh_done", {30'b0, dm_done, dm_err}, 32'b10);
    step();
    dm_issue(1'b0, 1'b1, MEM_B, 32'h201, 32'h1234ABCD);
    chk("sb_be", {28'b0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hCDCDCDCD);
    ack_step('0);
    step();

    // pre-check errors: done+err at cycle 1, no mem_req
    dm_issue(1'b1, 1'b0, MEM_W, 32'h201, '0);
    chk("lw_mis_done_err", {30'b0, dm_done, dm_err}, 32'b11);
    chk("lw_mis_no_req", {31'b0, mem_req}, 32'd0);
    step();
    chk("lw_mis_pulse", {30'b0, dm_done, mem_req}, 32'd0);
    dm_issue(1'b1, 1'b1, MEM_W, 32'h200, '0);
    chk("rdwr_done_err", {30'b0, dm_done, dm_err}, 32'b11);
    chk("rdwr_no_req", {31'b0, mem_req}, 32'd0);
    step();
    dm_issue(1'b0, 1'b1, MEM_BU, 32'h200, '0);
    chk("st_bu_err", {30'b0, dm_done, dm_err}, 32'b11);
    step();
    dm_issue(1'b1, 1'b0, MEM_NONE, 32'h200, '0);
    chk("mode_none_err", {30'b0, dm_done, dm_err}, 32'b11);
    step();
    if_req = 1'b1; if_addr = 32'h102;
    step();
    if_req = 1'b0;
    chk("if_mis_done_err", {30'b0, if_done, if_err}, 32'b11);
    chk("if_mis_no_req", {31'b0, mem_req}, 32'd0);
    step();

    // fairness: both held, ack always high -> D D D D I repeating
    if_req = 1'b1; if_addr = 32'h40;
    dm_rd_en = 1'b1; dm_acc_mode = MEM_W; dm_addr = 32'h300;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    ev = 0; cyc = 0;
    while (ev < 10 && cyc < 60) begin
      step(); cyc++;
      if (if_done || dm_done) begin
        chk($sformatf("fair_ev%0d", ev), {31'b0, if_done}, (ev % 5 == 4) ? 32'd1 : 32'd0);
        ev++;
      end
    end
    chk("fair_events", ev, 32'd10);
    if_req = 1'b0; dm_rd_en = 1'b0; mem_ack = 1'b0;
    step();

    // timeout: 16 cycles of mem_req, then err with zero data
    dm_issue(1'b1, 1'b0, MEM_W, 32'h400, '0);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", cnt, 32'd16);
    chk("to_done_err", {30'b0, dm_done, dm_err}, 32'b11);
    chk("to_rdata", dm_rdata, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    step();
    chk("to_late_ack", {30'b0, dm_done, if_done}, 32'd0);
    step();
    chk("to_late_ack2", {30'b0, dm_done, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // reset mid-WAIT
    if_req = 1'b1; if_addr = 32'h500;
    step(); step();
    chk("rst_wait_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1; if_req = 1'b0;
    step();
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_be", {28'b0, mem_be}, 32'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55;
    step();
    chk("rst_ack_ignored", {29'b0, if_done, dm_done, mem_req}, 32'd0);
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
